// File: rtl/alu_bus_arbiter_if.sv
// Bus bundle between the eight requesters, the arbiter and the downstream consumer.
// The master modport is the arbiter's view; the slave modport is the requester/consumer side.
interface alu_bus_arbiter_if;
  logic [7:0] req;
  logic [7:0] lock;
  logic       out_ready;
  logic [7:0] grant;
  logic       sel2;
  logic       sel1;
  logic       sel0;
  logic       out_valid;

  modport master (
    input  req, lock, out_ready,
    output grant, sel2, sel1, sel0, out_valid
  );

  modport slave (
    output req, lock, out_ready,
    input  grant, sel2, sel1, sel0, out_valid
  );
endinterface

// File: rtl/alu_bus_arbiter.sv
// Round-robin owner arbiter for an 8-input mux bus, with locked multi-beat ownership.
// Optional macro ALU_ARB_FIXED_PRIO_EN: replaces round-robin with fixed lowest-index priority.
module alu_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic               clk,
  input logic               rst,
  alu_bus_arbiter_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  localparam logic [8:0] MAX_HOLD_W = 9'(MAX_HOLD);

  state_t     state_r, state_s;
  logic [2:0] owner_r, owner_s;
  logic [2:0] rr_ptr_r, rr_ptr_s;
  logic [7:0] beat_cnt_r, beat_cnt_s;
  logic [7:0] grant_r, grant_s;
  logic [2:0] sel_r, sel_s;

  logic       out_valid_s;
  logic       do_arb_s;
  logic [7:0] scan_req_s;
  logic [2:0] scan_ptr_s;
  logic [3:0] pick_s;

  // Returns {found, index} of the first set bit scanning upward from ptr, modulo 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] req_v, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + k[2:0];
      if (req_v[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign out_valid_s = (state_r == OWN) && bus.req[owner_r];

  // Next-state logic: hold, keep a locked owner, or release and re-arbitrate in the same cycle.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    rr_ptr_s   = rr_ptr_r;
    beat_cnt_s = beat_cnt_r;
    grant_s    = grant_r;
    sel_s      = sel_r;
    do_arb_s   = 1'b0;
    scan_req_s = bus.req;
    scan_ptr_s = FIXED_PRIO ? 3'd0 : rr_ptr_r;

    case (state_r)
      IDLE: begin
        do_arb_s = 1'b1;
        grant_s  = 8'h00;
      end
      OWN: begin
        if (!bus.req[owner_r]) begin
          // Abandoned beat: the owner is not eligible in the re-arbitration.
          do_arb_s   = 1'b1;
          scan_req_s = bus.req & ~(8'h01 << owner_r);
          rr_ptr_s   = FIXED_PRIO ? 3'd0 : owner_r + 3'd1;
          scan_ptr_s = FIXED_PRIO ? 3'd0 : owner_r + 3'd1;
        end else if (bus.out_ready) begin
          if (bus.lock[owner_r] && (({1'b0, beat_cnt_r} + 9'd1) < MAX_HOLD_W)) begin
            beat_cnt_s = beat_cnt_r + 8'd1;
          end else begin
            beat_cnt_s = beat_cnt_r + 8'd1;
            do_arb_s   = 1'b1;
            rr_ptr_s   = FIXED_PRIO ? 3'd0 : owner_r + 3'd1;
            scan_ptr_s = FIXED_PRIO ? 3'd0 : owner_r + 3'd1;
          end
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = 8'h00;
      end
    endcase

    pick_s = rr_pick(scan_req_s, scan_ptr_s);

    if (do_arb_s) begin
      if (pick_s[3]) begin
        state_s    = OWN;
        owner_s    = pick_s[2:0];
        grant_s    = 8'h01 << pick_s[2:0];
        sel_s      = pick_s[2:0];
        beat_cnt_s = 8'd0;
      end else begin
        state_s = IDLE;
        grant_s = 8'h00;
      end
    end else begin
      state_s = state_s;
    end
  end

  // State and registered grant/select outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      owner_r    <= 3'd0;
      rr_ptr_r   <= 3'd0;
      beat_cnt_r <= 8'd0;
      grant_r    <= 8'h00;
      sel_r      <= 3'd0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      rr_ptr_r   <= rr_ptr_s;
      beat_cnt_r <= beat_cnt_s;
      grant_r    <= grant_s;
      sel_r      <= sel_s;
    end
  end

  assign bus.grant     = grant_r;
  assign bus.sel2      = sel_r[2];
  assign bus.sel1      = sel_r[1];
  assign bus.sel0      = sel_r[0];
  assign bus.out_valid = out_valid_s;

endmodule

// File: tb/tb_alu_bus_arbiter.sv
// Directed self-checking bench for alu_bus_arbiter (MAX_HOLD=4); expectations follow ALU_ARB_FIXED_PRIO_EN.
module tb_alu_bus_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  alu_bus_arbiter_if bus ();

  alu_bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [2:0] sel_of();
    return {bus.sel2, bus.sel1, bus.sel0};
  endfunction

  logic [7:0] exp_g;
  logic [2:0] exp_i;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req       = 8'h00;
    bus.lock      = 8'h00;
    bus.out_ready = 1'b0;
    #12;
    chk("reset_grant", 32'(bus.grant), 32'h0);
    chk("reset_sel", 32'(sel_of()), 32'h0);
    chk("reset_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;

    // Single requester streaming without gaps
    bus.req = 8'h04;
    bus.out_ready = 1'b1;
    #1;
    chk("single_c0_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_grant", 32'(bus.grant), 32'h04);
      chk("single_sel", 32'(sel_of()), 32'h2);
      chk("single_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.req = 8'h00;
    tick();
    chk("idle_grant", 32'(bus.grant), 32'h0);
    chk("idle_sel_hold", 32'(sel_of()), 32'h2);
    chk("idle_valid", 32'(bus.out_valid), 32'h0);

    // Fairness across all eight requesters
    pulse_reset();
    bus.req = 8'hFF;
    bus.lock = 8'h00;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_i = FIXED ? 3'd0 : 3'(i % 8);
      exp_g = 8'h01 << exp_i;
      chk("fair_grant", 32'(bus.grant), 32'(exp_g));
      chk("fair_sel", 32'(sel_of()), 32'(exp_i));
      chk("fair_valid", 32'(bus.out_valid), 32'h1);
    end

    // Stall with owner 3, requester 4 pending
    pulse_reset();
    bus.req = 8'h18;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_grant", 32'(bus.grant), 32'h08);
      chk("stall_sel", 32'(sel_of()), 32'h3);
      chk("stall_valid", 32'(bus.out_valid), 32'h1);
      chk("stall_cnt", 32'(dut.beat_cnt_r), 32'h0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("stall_next_grant", 32'(bus.grant), FIXED ? 32'h08 : 32'h10);

    // Lock limit: owner 0 keeps 4 beats, then requester 5, then 0 again
    pulse_reset();
    bus.req = 8'h21;
    bus.lock = 8'h01;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_g = (i == 4 && !FIXED) ? 8'h20 : 8'h01;
      chk("lock_grant", 32'(bus.grant), 32'(exp_g));
    end
    bus.lock = 8'h00;

    // Abandon by owner 6 (with out_ready rising the same cycle), then by owner 7
    pulse_reset();
    bus.req = 8'h40;
    bus.out_ready = 1'b0;
    tick();
    chk("aband_grant6", 32'(bus.grant), 32'h40);
    bus.req = 8'h80;
    bus.out_ready = 1'b1;
    #1;
    chk("aband_valid", 32'(bus.out_valid), 32'h0);
    tick();
    chk("aband_grant7", 32'(bus.grant), 32'h80);
    chk("aband_sel7", 32'(sel_of()), 32'h7);
    bus.req = 8'h00;
    tick();
    chk("aband_idle", 32'(bus.grant), 32'h0);

    // Asynchronous reset in the middle of a beat
    bus.req = 8'h02;
    bus.out_ready = 1'b0;
    tick();
    chk("mid_grant", 32'(bus.grant), 32'h02);
    chk("mid_valid", 32'(bus.out_valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_sel", 32'(sel_of()), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;

    // Two requesters 1 and 3 held continuously
    bus.req = 8'h0A;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_g = (FIXED || (i % 2 == 0)) ? 8'h02 : 8'h08;
      chk("pair_grant", 32'(bus.grant), 32'(exp_g));
    end
    bus.req = 8'h00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
